// File: rtl/i2s_tdm_tx.sv
// I2S / left-justified / TDM audio serialiser with a one-frame holding buffer.
// BCLK, WS and SD are all generated from clk_in by an internal divider.
module i2s_tdm_tx #(
  parameter int unsigned SAMPLE_W = 16,
  parameter int unsigned SLOT_W   = 16,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned BCLK_DIV = 4
) (
  input  logic                         clk_in,
  input  logic                         reset_in,
  input  logic                         enable_in,
  input  logic                         mode_in,
  input  logic [CHANNELS*SAMPLE_W-1:0] sample_in,
  input  logic                         sample_valid_in,
  output logic                         sample_ready_out,
  output logic                         i2s_bclk_out,
  output logic                         i2s_ws_out,
  output logic                         i2s_d_out,
  output logic                         frame_start_out,
  output logic                         underrun_out
);

  localparam int unsigned FRAME = CHANNELS * SLOT_W;
  localparam int unsigned CW    = $clog2(BCLK_DIV);
  localparam int unsigned PW    = $clog2(FRAME);
  localparam logic [CW-1:0] CNT_LAST = CW'(BCLK_DIV - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(BCLK_DIV / 2);
  localparam logic [PW-1:0] P_LAST   = PW'(FRAME - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_STOP} state_t;

  state_t                        state_q, state_d;
  logic [CW-1:0]                 cnt_q, cnt_d;
  logic [PW-1:0]                 p_q, p_d;
  logic [FRAME-1:0]              shift_q, shift_d;
  logic                          mode_q, mode_d;
  logic [CHANNELS*SAMPLE_W-1:0]  buf_q, buf_d;
  logic                          buf_full_q, buf_full_d;
  logic                          bclk_q, bclk_d;
  logic                          ws_q, ws_d;
  logic                          d_q, d_d;
  logic                          fs_q, fs_d;
  logic                          ur_q, ur_d;

  logic [FRAME-1:0] frame_vec;
  logic [PW-1:0]    q_ws;
  logic             frame_end, start, accept, adv;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    p_d        = p_q;
    shift_d    = shift_q;
    mode_d     = mode_q;
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    ws_d       = ws_q;
    d_d        = d_q;
    adv        = 1'b0;
    q_ws       = '0;

    // Slot 0 occupies the frame MSBs; sample sits at the top of its slot.
    frame_vec = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      frame_vec[FRAME-1-c*SLOT_W -: SAMPLE_W] = buf_q[c*SAMPLE_W +: SAMPLE_W];
    end

    frame_end = (state_q != ST_IDLE) && (cnt_q == CNT_LAST) && (p_q == P_LAST);
    start     = enable_in && ((state_q == ST_IDLE) || frame_end);
    accept    = sample_valid_in && !buf_full_q;
    fs_d      = start;
    ur_d      = start && !buf_full_q;

    if (accept) begin
      buf_d      = sample_in;
      buf_full_d = 1'b1;
    end else if (start && buf_full_q) begin
      buf_full_d = 1'b0;
    end

    case (state_q)
      ST_IDLE: state_d = enable_in ? ST_RUN : ST_IDLE;
      default: begin
        if (enable_in)      state_d = ST_RUN;
        else if (frame_end) state_d = ST_IDLE;
        else                state_d = ST_STOP;
      end
    endcase

    if (start) begin
      cnt_d   = '0;
      p_d     = '0;
      mode_d  = mode_in;
      shift_d = buf_full_q ? frame_vec : '0;
      adv     = 1'b1;
    end else if (state_d == ST_IDLE) begin
      cnt_d = '0;
      p_d   = '0;
      ws_d  = 1'b0;
      d_d   = 1'b0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      p_d     = p_q + PW'(1);
      shift_d = shift_q << 1;
      adv     = 1'b1;
    end else begin
      cnt_d = cnt_q + CW'(1);
    end

    // I2S mode looks one bit ahead so WS leads the slot MSB by one BCLK.
    if (adv) begin
      d_d  = shift_d[FRAME-1];
      q_ws = mode_d ? p_d : ((p_d == P_LAST) ? '0 : p_d + PW'(1));
      ws_d = (CHANNELS > 2) ? (q_ws == '0) : (q_ws >= PW'(SLOT_W));
    end

    bclk_d = (cnt_d >= CNT_HALF);
  end

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      p_q        <= '0;
      shift_q    <= '0;
      mode_q     <= 1'b0;
      buf_q      <= '0;
      buf_full_q <= 1'b0;
      bclk_q     <= 1'b0;
      ws_q       <= 1'b0;
      d_q        <= 1'b0;
      fs_q       <= 1'b0;
      ur_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      p_q        <= p_d;
      shift_q    <= shift_d;
      mode_q     <= mode_d;
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
      bclk_q     <= bclk_d;
      ws_q       <= ws_d;
      d_q        <= d_d;
      fs_q       <= fs_d;
      ur_q       <= ur_d;
    end
  end

  assign sample_ready_out = ~buf_full_q;
  assign i2s_bclk_out     = bclk_q;
  assign i2s_ws_out       = ws_q;
  assign i2s_d_out        = d_q;
  assign frame_start_out  = fs_q;
  assign underrun_out     = ur_q;

endmodule
